// File: rtl/ro_freq_meter_pkg.sv
// Shared types and default widths for the ring-oscillator frequency meter.
package ro_meas_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_GATE_W      = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/ro_freq_meter_if.sv
// Request/result bundle between a measurement client (master) and the meter (slave).
interface ro_freq_meter_if
  import ro_meas_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned GATE_W = DEF_GATE_W
);
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic              busy;
  logic              overflow;
`ifdef RESULT_SHIFT_EN
  logic              ser_req;
  logic              ser_data;
  logic              ser_busy;

  modport master (output start, gate_len, ser_req,
                  input  count, valid, busy, overflow, ser_data, ser_busy);
  modport slave  (input  start, gate_len, ser_req,
                  output count, valid, busy, overflow, ser_data, ser_busy);
`else
  modport master (output start, gate_len,
                  input  count, valid, busy, overflow);
  modport slave  (input  start, gate_len,
                  output count, valid, busy, overflow);
`endif
endinterface

// File: rtl/ro_freq_meter_edge_sync.sv
// Synchronises an asynchronous oscillator into clk and emits a one-cycle pulse per rising edge.
module ro_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Gated rising-edge counter for a ring oscillator; optional serial result readout
// when RESULT_SHIFT_EN is defined. Oscillators at or above clk/2 alias.
module ro_freq_meter
  import ro_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned GATE_W      = DEF_GATE_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic osc_in,
  ro_freq_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ALL_ONES = {CNT_W{1'b1}};

  state_t            state;
  logic [GATE_W-1:0] gate_ctr;
  logic              zero_pend;
  logic              rise_c;
  logic              accept_c;

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (osc_in),
    .rise_c   (rise_c)
  );

  assign accept_c = ena & bus.start & (state != COUNT);

  // Measurement FSM; a zero-length gate completes one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      gate_ctr     <= '0;
      zero_pend    <= 1'b0;
      bus.count    <= '0;
      bus.valid    <= 1'b0;
      bus.busy     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            bus.count    <= '0;
            bus.overflow <= 1'b0;
            bus.valid    <= 1'b0;
            gate_ctr     <= bus.gate_len;
            if (bus.gate_len != '0) begin
              state     <= COUNT;
              bus.busy  <= 1'b1;
              zero_pend <= 1'b0;
            end else begin
              state     <= DONE;
              zero_pend <= 1'b1;
            end
          end else if (zero_pend) begin
            bus.valid <= 1'b1;
            zero_pend <= 1'b0;
          end
        end
        COUNT: begin
          if (!ena) begin
            state     <= IDLE;
            gate_ctr  <= '0;
            bus.count <= '0;
            bus.busy  <= 1'b0;
            bus.valid <= 1'b0;
          end else begin
            if (rise_c) begin
              if (bus.count == CNT_ALL_ONES) bus.overflow <= 1'b1;
              else                           bus.count    <= bus.count + CNT_W'(1);
            end
            gate_ctr <= gate_ctr - GATE_W'(1);
            if (gate_ctr == GATE_W'(1)) begin
              state     <= DONE;
              bus.busy  <= 1'b0;
              bus.valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RESULT_SHIFT_EN
  localparam int unsigned SER_CW = $clog2(CNT_W + 1);

  logic [CNT_W-1:0]  shreg;
  logic [SER_CW-1:0] ser_cnt;

  // MSB-first shifter; a new accepted measurement cancels any readout in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg        <= '0;
      ser_cnt      <= '0;
      bus.ser_busy <= 1'b0;
    end else if (accept_c) begin
      shreg        <= '0;
      ser_cnt      <= '0;
      bus.ser_busy <= 1'b0;
    end else if (bus.ser_busy) begin
      shreg   <= {shreg[CNT_W-2:0], 1'b0};
      ser_cnt <= ser_cnt - SER_CW'(1);
      if (ser_cnt == SER_CW'(1)) bus.ser_busy <= 1'b0;
    end else if (bus.ser_req && state == DONE) begin
      shreg        <= bus.count;
      ser_cnt      <= SER_CW'(CNT_W);
      bus.ser_busy <= 1'b1;
    end
  end

  assign bus.ser_data = shreg[CNT_W-1];
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit instance plus a 4-bit instance for saturation.
module tb_ro_freq_meter;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic osc_in = 1'b0;

  int unsigned osc_period = 4;
  int unsigned osc_cnt    = 0;

  int checks = 0;
  int errors = 0;

  ro_freq_meter_if #(.CNT_W(16), .GATE_W(16)) a ();
  ro_freq_meter_if #(.CNT_W(4),  .GATE_W(16)) s ();

  ro_freq_meter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) u_dut (
    .clk (clk), .rst_n (rst_n), .ena (ena), .osc_in (osc_in), .bus (a.slave)
  );

  ro_freq_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) u_sat (
    .clk (clk), .rst_n (rst_n), .ena (ena), .osc_in (osc_in), .bus (s.slave)
  );

  always #5 clk = ~clk;

  // Oscillator synchronous to clk but offset from the edge; high for the first half-period.
  initial forever begin
    @(posedge clk);
    #2;
    osc_cnt = (osc_cnt + 1) % osc_period;
    osc_in  = (osc_cnt < osc_period / 2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    a.start    = 1'b0;
    a.gate_len = '0;
    s.start    = 1'b0;
    s.gate_len = '0;
`ifdef RESULT_SHIFT_EN
    a.ser_req  = 1'b0;
    s.ser_req  = 1'b0;
`endif

    // Reset with oscillator toggling
    repeat (3) tick();
    chk("rst_count",    32'(a.count),    32'd0);
    chk("rst_valid",    32'(a.valid),    32'd0);
    chk("rst_busy",     32'(a.busy),     32'd0);
    chk("rst_overflow", 32'(a.overflow), 32'd0);
    chk("rst_sat_cnt",  32'(s.count),    32'd0);

    rst_n      = 1'b1;
    osc_period = 8;
    repeat (12) tick();

    // Nominal: period 8, 64-cycle window -> 8 edges
    a.gate_len = 16'd64;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    chk("nom_busy_on",   32'(a.busy),  32'd1);
    chk("nom_valid_off", 32'(a.valid), 32'd0);
    repeat (63) tick();
    chk("nom_busy_last", 32'(a.busy),  32'd1);
    tick();
    chk("nom_busy_off",  32'(a.busy),     32'd0);
    chk("nom_valid",     32'(a.valid),    32'd1);
    chk("nom_count",     32'(a.count),    32'd8);
    chk("nom_overflow",  32'(a.overflow), 32'd0);

    // ena low in DONE: start rejected, result holds
    ena        = 1'b0;
    a.gate_len = 16'd5;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    ena        = 1'b1;
    chk("hold_valid", 32'(a.valid), 32'd1);
    chk("hold_count", 32'(a.count), 32'd8);
    chk("hold_busy",  32'(a.busy),  32'd0);

    // Zero gate
    a.gate_len = 16'd0;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    chk("zg_valid_accept", 32'(a.valid), 32'd0);
    chk("zg_busy_accept",  32'(a.busy),  32'd0);
    tick();
    chk("zg_valid", 32'(a.valid), 32'd1);
    chk("zg_busy",  32'(a.busy),  32'd0);
    chk("zg_count", 32'(a.count), 32'd0);

    // Saturation on the 4-bit instance: period 4 over 200 cycles -> 50 edges
    osc_period = 4;
    repeat (10) tick();
    s.gate_len = 16'd200;
    s.start    = 1'b1;
    tick();
    s.start    = 1'b0;
    repeat (200) tick();
    chk("sat_valid",    32'(s.valid),    32'd1);
    chk("sat_count",    32'(s.count),    32'd15);
    chk("sat_overflow", 32'(s.overflow), 32'd1);
    s.gate_len = 16'd10;
    s.start    = 1'b1;
    tick();
    s.start    = 1'b0;
    chk("sat_ovf_clear", 32'(s.overflow), 32'd0);
    chk("sat_restart",   32'(s.busy),     32'd1);

    // start/gate_len while busy are ignored: window stays 20 cycles
    osc_period = 8;
    repeat (12) tick();
    a.gate_len = 16'd20;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    repeat (5) tick();
    a.gate_len = 16'd3;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    repeat (13) tick();
    chk("ign_busy_19", 32'(a.busy),  32'd1);
    tick();
    chk("ign_busy_20", 32'(a.busy),  32'd0);
    chk("ign_valid",   32'(a.valid), 32'd1);

    // ena drop mid-COUNT aborts
    a.gate_len = 16'd40;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    repeat (20) tick();
    chk("abort_partial", 32'(a.count >= 16'd2), 32'd1);
    ena = 1'b0;
    tick();
    chk("abort_busy",  32'(a.busy),  32'd0);
    chk("abort_valid", 32'(a.valid), 32'd0);
    chk("abort_count", 32'(a.count), 32'd0);
    tick();
    chk("abort_idle_busy", 32'(a.busy), 32'd0);
    ena = 1'b1;

    // Normal measurement after abort: period 8, 32 cycles -> 4 edges
    a.gate_len = 16'd32;
    a.start    = 1'b1;
    tick();
    a.start    = 1'b0;
    repeat (32) tick();
    chk("post_valid", 32'(a.valid), 32'd1);
    chk("post_busy",  32'(a.busy),  32'd0);
    chk("post_count", 32'(a.count), 32'd4);

`ifdef RESULT_SHIFT_EN
    begin
      logic [15:0] exp_word;
      exp_word  = 16'h0004;
      a.ser_req = 1'b1;
      tick();
      a.ser_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
        chk("ser_busy_on", 32'(a.ser_busy), 32'd1);
        chk("ser_bit",     32'(a.ser_data), 32'(exp_word[15-i]));
        tick();
      end
      chk("ser_busy_off", 32'(a.ser_busy), 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
